// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - burst reader from a 1-cycle-latency SRAM into a ready/valid stream
// Optional feature: define SRAM_STREAM_STALL_CNT_EN to add the stall_cnt output.
module sram_stream_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data_i,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
`ifdef SRAM_STREAM_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic [1:0]            fifo_count;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  issue_last;
  logic                  accept_start;
  logic [2:0]            credit;

  // A read is outstanding from issue until its word leaves the FIFO; the
  // credit is that count after this cycle's pop, and must stay below 2.
  assign pop          = m_valid & m_ready;
  assign push         = inflight;
  assign accept_start = (state == IDLE) & start;
  assign credit       = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue_last   = issue & (remaining == REM_ONE);

  assign sram_en   = issue;
  assign sram_we   = 1'b0;
  assign sram_addr = rd_ptr;
  assign busy      = (state != IDLE);
  assign m_valid   = (fifo_count != 2'd0);
  assign m_data    = fifo_data[fifo_rd];
  assign m_last    = m_valid & fifo_last[fifo_rd];

  // Next-state and read-issue decision.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start && (length != '0)) state_nxt = RUN;
      end
      RUN: begin
        issue = (remaining != '0) && (credit < 3'd2);
        if (issue && (remaining == REM_ONE)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Read pointer, word countdown and the one-cycle SRAM latency tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (accept_start) begin
        rd_ptr    <= base_addr;
        remaining <= length;
      end else if (issue) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        remaining <= remaining - REM_ONE;
      end
      inflight      <= issue;
      inflight_last <= issue_last;
    end
  end

  // FIFO payload storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_data[fifo_wr] <= sram_data_i;
  end

  // FIFO pointers, occupancy and per-entry last-word flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr    <= 1'b0;
      fifo_rd    <= 1'b0;
      fifo_count <= 2'd0;
      fifo_last  <= 2'b00;
    end else begin
      if (push) begin
        fifo_last[fifo_wr] <= inflight_last;
        fifo_wr            <= ~fifo_wr;
      end
      if (pop) fifo_rd <= ~fifo_rd;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Completion pulse: zero-length request, or transfer of the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (accept_start && (length == '0)) ||
                        ((state == DRAIN) && pop && m_last);
  end

`ifdef SRAM_STREAM_STALL_CNT_EN
  // Saturating count of cycles where a word waits on downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    stall_cnt <= 16'h0000;
    else if (accept_start)                         stall_cnt <= 16'h0000;
    else if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - directed self-checking bench for sram_stream_reader
module tb_sram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] length;
  logic        sram_en;
  logic        sram_we;
  logic [10:0] sram_addr;
  logic [11:0] sram_data_i;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;
`ifdef SRAM_STREAM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  sram_stream_reader #(.DATA_WIDTH(12), .ADDR_WIDTH(11)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_data_i (sram_data_i),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
`ifdef SRAM_STREAM_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;

  // Fixed RAM image: injective in the address so every word is distinct.
  function automatic logic [11:0] ram_word(input logic [10:0] a);
    ram_word = {a[3:0], a[10:3]} ^ 12'hA5C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SRAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (sram_en) sram_data_i <= ram_word(sram_addr);
    else         sram_data_i <= 12'hXXX;
  end

  // Cycle counter.
  always @(posedge clk) cyc = cyc + 1;

  logic [10:0] addr_q [$];
  logic [11:0] data_q [$];
  bit          last_q [$];
  bit          mon_clr = 1'b0;
  bit          mon_pop;
  int          outstanding, credit_viol, hold_viol, done_cnt;
  int          done_cyc, first_valid_cyc, first_en_cyc, last_en_cyc;
  bit          busy_seen, we_seen, prev_stall;
  logic [11:0] prev_data;

  // Stream/SRAM monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_clr) begin
      addr_q.delete(); data_q.delete(); last_q.delete();
      outstanding = 0; credit_viol = 0; hold_viol = 0; done_cnt = 0;
      done_cyc = -1; first_valid_cyc = -1; first_en_cyc = -1; last_en_cyc = -1;
      busy_seen = 1'b0; we_seen = 1'b0; prev_stall = 1'b0;
    end else begin
      mon_pop = m_valid && m_ready;
      if (sram_en) begin
        if (outstanding - (mon_pop ? 1 : 0) >= 2) credit_viol++;
        addr_q.push_back(sram_addr);
        if (first_en_cyc < 0) first_en_cyc = cyc;
        last_en_cyc = cyc;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && (!m_valid || m_data !== prev_data)) hold_viol++;
      if (mon_pop) begin
        data_q.push_back(m_data);
        last_q.push_back(m_last);
      end
      outstanding = outstanding + (sram_en ? 1 : 0) - (mon_pop ? 1 : 0);
      if (!rst_n) outstanding = 0;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_seen = 1'b1;
      if (sram_we) we_seen = 1'b1;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  function automatic logic rdy(input int mode, input int i);
    case (mode)
      1:       rdy = ((i % 4) == 0) || ((i % 4) == 3);
      2:       rdy = !((i >= 3) && (i <= 12));
      default: rdy = 1'b1;
    endcase
  endfunction

  task automatic run(input logic [10:0] b, input logic [11:0] l, input int mode, input bit inj);
    bit finished;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr   = 1'b0;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    m_ready   = rdy(mode, 0);
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
    finished  = done;
    for (int i = 1; i < 300 && !finished; i++) begin
      m_ready = rdy(mode, i);
      if (inj && i == 4) begin
        start = 1'b1; base_addr = 11'h000; length = 12'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      finished = done;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    check_eq("done_timeout", {31'd0, finished}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_burst(input logic [10:0] b, input int l);
    logic [10:0] ea;
    check_eq("n_addr", addr_q.size(), l);
    check_eq("n_data", data_q.size(), l);
    for (int i = 0; i < l; i++) begin
      ea = b + 11'(i);
      if (i < addr_q.size()) check_eq($sformatf("addr[%0d]", i), {21'd0, addr_q[i]}, {21'd0, ea});
      if (i < data_q.size()) begin
        check_eq($sformatf("data[%0d]", i), {20'd0, data_q[i]}, {20'd0, ram_word(ea)});
        check_eq($sformatf("last[%0d]", i), {31'd0, last_q[i]}, {31'd0, (i == l - 1)});
      end
    end
    check_eq("credit_viol", credit_viol, 0);
    check_eq("hold_viol", hold_viol, 0);
    check_eq("done_cnt", done_cnt, 1);
    check_eq("busy_after", {31'd0, busy}, 32'd0);
    check_eq("we_seen", {31'd0, we_seen}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check_eq({pfx, "_m_last"}, {31'd0, m_last}, 32'd0);
    check_eq({pfx, "_done"}, {31'd0, done}, 32'd0);
    check_eq({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({pfx, "_sram_en"}, {31'd0, sram_en}, 32'd0);
    check_eq({pfx, "_sram_addr"}, {21'd0, sram_addr}, 32'd0);
    check_eq({pfx, "_sram_we"}, {31'd0, sram_we}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit got5;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic burst with timing.
    run(11'h010, 12'd4, 0, 1'b0);
    check_burst(11'h010, 4);
    check_eq("first_en_lat", first_en_cyc - start_cyc, 0);
    check_eq("en_span", last_en_cyc - first_en_cyc, 3);
    check_eq("valid_lat", first_valid_cyc - start_cyc, 2);
    check_eq("done_lat", done_cyc - start_cyc, 6);

    // Address wrap.
    run(11'h7FE, 12'd4, 0, 1'b0);
    check_burst(11'h7FE, 4);

    // Backpressure pattern plus a start that must be ignored while busy.
    run(11'h200, 12'd8, 1, 1'b1);
    check_burst(11'h200, 8);

    // Zero-length request.
    run(11'h123, 12'd0, 0, 1'b0);
    check_eq("len0_n_addr", addr_q.size(), 0);
    check_eq("len0_busy_seen", {31'd0, busy_seen}, 32'd0);
    check_eq("len0_done_cnt", done_cnt, 1);
    check_eq("len0_done_lat", done_cyc - start_cyc, 0);

    // Reset in the middle of a long burst.
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    start = 1'b1; base_addr = 11'h300; length = 12'd16; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got5 = 1'b0;
    for (int i = 0; i < 100 && !got5; i++) begin
      @(posedge clk); #1;
      got5 = (data_q.size() >= 5);
    end
    check_eq("rst_wait5", {31'd0, got5}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("rst_hold_done%0d", i), {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_no_done", done_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < data_q.size())
        check_eq($sformatf("rst_data[%0d]", i), {20'd0, data_q[i]}, {20'd0, ram_word(11'h300 + 11'(i))});
    end
    run(11'h100, 12'd2, 0, 1'b0);
    check_burst(11'h100, 2);

`ifdef SRAM_STREAM_STALL_CNT_EN
    run(11'h040, 12'd4, 2, 1'b0);
    check_burst(11'h040, 4);
    check_eq("stall_cnt", {16'd0, stall_cnt}, 32'd10);
    run(11'h050, 12'd1, 0, 1'b0);
    check_burst(11'h050, 1);
    check_eq("stall_clr", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
